// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: captures ALU flags and evaluates branch conditions against them.
// Taken branches produce a registered redirect to fetch over a valid/ready handshake.
module branch_resolve_unit #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_overflow,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic [2:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt
);

  // state    | meaning
  // IDLE     | ready to accept and evaluate a branch
  // REDIRECT | taken branch's redirect held until fetch accepts it
  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t     state, state_nxt;
  logic [2:0] flags_eff;
  logic       cond_met;
  logic       take;

  // A flag write in the same cycle as a branch is visible to that branch.
  assign flags_eff = flag_we ? {flag_overflow, flag_sign, flag_zero} : flags_q;

  always_comb begin
    cond_met = 1'b0;
    case (br_cond)
      3'd0: cond_met = 1'b1;
      3'd1: cond_met = flags_eff[0];
      3'd2: cond_met = ~flags_eff[0];
      3'd3: cond_met = flags_eff[1] ^ flags_eff[2];
      3'd4: cond_met = ~(flags_eff[1] ^ flags_eff[2]);
      3'd5: cond_met = flags_eff[2];
      3'd6: cond_met = flags_eff[1];
      3'd7: cond_met = 1'b0;
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (br_valid && cond_met) begin
          take      = 1'b1;
          state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign br_ready       = (state == IDLE);
  assign redirect_valid = (state == REDIRECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
    end else if (flag_we) begin
      flags_q <= {flag_overflow, flag_sign, flag_zero};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      redirect_addr <= '0;
      taken_cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        redirect_addr <= br_target;
        if (taken_cnt != {CNT_W{1'b1}}) taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_branch_resolve_unit;
  localparam int AW   = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flag_we = 1'b0, flag_zero = 1'b0, flag_sign = 1'b0, flag_overflow = 1'b0;
  logic          br_valid = 1'b0;
  logic          br_ready;
  logic [2:0]    br_cond = 3'd0;
  logic [AW-1:0] br_target = '0;
  logic          redirect_valid;
  logic          redirect_ready = 1'b0;
  logic [AW-1:0] redirect_addr;
  logic [2:0]    flags_q;
  logic [CW-1:0] taken_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [2:0]    m_flags;
  logic          m_pend;
  logic [AW-1:0] m_addr;
  int            m_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .flag_we(flag_we), .flag_zero(flag_zero), .flag_sign(flag_sign), .flag_overflow(flag_overflow),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_addr(redirect_addr),
    .flags_q(flags_q), .taken_cnt(taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {V, S, Z}
  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit z, s, v;
    z = f[0]; s = f[1]; v = f[2];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return s != v;
      3'd4: return s == v;
      3'd5: return v;
      3'd6: return s;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 3'b000; m_pend = 1'b0; m_addr = '0; m_cnt = 0;
  endtask

  // Advance the model by one cycle from the current inputs, clock the DUT, compare.
  task automatic tick();
    logic [2:0] nf, eff;
    nf  = {flag_overflow, flag_sign, flag_zero};
    eff = flag_we ? nf : m_flags;
    if (!m_pend) begin
      if (br_valid && cond_ok(br_cond, eff)) begin
        m_pend = 1'b1;
        m_addr = br_target;
        if (m_cnt < CMAX) m_cnt++;
      end
    end else if (redirect_ready) begin
      m_pend = 1'b0;
    end
    if (flag_we) m_flags = nf;
    @(posedge clk);
    #1;
    check("flags_q", 32'(flags_q), 32'(m_flags));
    check("redirect_valid", 32'(redirect_valid), 32'(m_pend));
    check("redirect_addr", 32'(redirect_addr), 32'(m_addr));
    check("taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    check("br_ready", 32'(br_ready), 32'(!m_pend));
  endtask

  task automatic set_br(input logic v, input logic [2:0] c, input logic [AW-1:0] t);
    br_valid = v; br_cond = c; br_target = t;
  endtask

  task automatic set_flags(input logic we, input logic v, input logic s, input logic z);
    flag_we = we; flag_overflow = v; flag_sign = s; flag_zero = z;
  endtask

  initial begin
    model_reset();
    #3;
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_addr", 32'(redirect_addr), 32'd0);
    check("rst_flags_q", 32'(flags_q), 32'd0);
    check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    #9 rst = 1'b0;
    #1 check("br_ready_after_rst", 32'(br_ready), 32'd1);

    // Flag write and EQ branch in the same cycle: bypass makes it taken.
    set_flags(1, 0, 0, 1);
    set_br(1, 3'd1, 16'h00A0);
    tick();
    check("bypass_valid", 32'(redirect_valid), 32'd1);
    check("bypass_addr", 32'(redirect_addr), 32'h00A0);
    check("bypass_flags", 32'(flags_q), 32'b001);
    check("bypass_cnt", 32'(taken_cnt), 32'd1);
    set_flags(0, 0, 0, 0);
    set_br(0, 3'd0, '0);
    redirect_ready = 1'b1;
    tick();

    // V=1,S=0,Z=0: LT taken, GE not taken.
    set_flags(1, 1, 0, 0);
    tick();
    set_flags(0, 0, 0, 0);
    set_br(1, 3'd3, 16'h0200);
    tick();
    check("lt_valid", 32'(redirect_valid), 32'd1);
    check("lt_addr", 32'(redirect_addr), 32'h0200);
    tick();
    set_br(1, 3'd4, 16'h0200);
    tick();
    check("ge_not_taken", 32'(redirect_valid), 32'd0);
    check("ge_cnt", 32'(taken_cnt), 32'd2);

    // Stalled redirect with a second request held, plus flag writes during REDIRECT.
    redirect_ready = 1'b0;
    set_br(1, 3'd0, 16'h0280);
    tick();
    set_br(1, 3'd0, 16'h0300);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_flags(1, 0, 0, 1);
      else if (i == 2) set_flags(1, 1, 0, 0);
      else set_flags(0, 0, 0, 0);
      tick();
      check("stall_addr", 32'(redirect_addr), 32'h0280);
      check("stall_ready", 32'(br_ready), 32'd0);
    end
    check("flag_in_redirect", 32'(flags_q), 32'b100);
    redirect_ready = 1'b1;
    tick();
    check("ack_idle", 32'(br_ready), 32'd1);
    redirect_ready = 1'b0;
    tick();
    check("second_addr", 32'(redirect_addr), 32'h0300);
    set_br(0, 3'd0, '0);
    redirect_ready = 1'b1;
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_flags(($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
      set_br(1'($urandom), 3'($urandom_range(0, 7)), 16'($urandom));
      redirect_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    set_br(0, 3'd0, '0);
    redirect_ready = 1'b1;
    set_flags(0, 0, 0, 0);
    tick();
    tick();

    // Asynchronous reset in the middle of a pending redirect.
    redirect_ready = 1'b0;
    set_flags(1, 1, 1, 1);
    set_br(1, 3'd0, 16'h1234);
    tick();
    check("pre_rst_addr", 32'(redirect_addr), 32'h1234);
    set_flags(0, 0, 0, 0);
    set_br(0, 3'd0, '0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_valid", 32'(redirect_valid), 32'd0);
    check("async_rst_flags", 32'(flags_q), 32'd0);
    check("async_rst_cnt", 32'(taken_cnt), 32'd0);
    check("async_rst_addr", 32'(redirect_addr), 32'd0);
    #2 rst = 1'b0;
    tick();
    check("no_retry", 32'(redirect_valid), 32'd0);

    // Counter saturation with 17 acknowledged ALWAYS branches.
    for (int i = 0; i < 17; i++) begin
      set_br(1, 3'd0, 16'(16'h0400 + i));
      redirect_ready = 1'b0;
      tick();
      set_br(0, 3'd0, '0);
      redirect_ready = 1'b1;
      tick();
    end
    check("sat_cnt", 32'(taken_cnt), 32'(CMAX));
    for (int i = 0; i < 3; i++) begin
      set_br(1, 3'd7, 16'hBEEF);
      tick();
      check("never_valid", 32'(redirect_valid), 32'd0);
      check("never_cnt", 32'(taken_cnt), 32'(CMAX));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the ALU status path: captures the zero/sign/overflow flags the ALU produces into an architectural flag register.
- Evaluates branch conditions against those flags and, for taken branches, issues a registered redirect to fetch over a valid/ready handshake.
- Sits between the execute stage (ALU status and branch request) and the fetch stage (redirect consumer).

Parameters:
ADDR_W, 16, width of branch target and redirect address
CNT_W, 16, width of saturating taken-branch counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flag_we  input  1  write ALU status into flag register this cycle
flag_zero  input  1  ALU zero flag
flag_sign  input  1  ALU sign flag
flag_overflow  input  1  ALU overflow flag (0 for logic ops)
br_valid  input  1  branch request present
br_ready  output  1  unit can accept a branch this cycle
br_cond  input  3  condition code
br_target  input  ADDR_W  branch target address
redirect_valid  output  1  redirect to fetch pending
redirect_ready  input  1  fetch accepts redirect
redirect_addr  output  ADDR_W  redirect target
flags_q  output  3  registered flags {overflow, sign, zero}
taken_cnt  output  CNT_W  count of taken branches, saturating

Behaviour:
- Reset, async and immediate: flags_q=0, redirect_valid=0, redirect_addr=0, taken_cnt=0, state=IDLE; br_ready=1 once rst is deasserted.
- Flag register:
  - On a clock edge with flag_we=1, flags_q <= {flag_overflow, flag_sign, flag_zero}.
  - Updates in any state, including REDIRECT.
- Effective flags for evaluation are the bypassed flags: the incoming flag inputs if flag_we=1 this cycle, else flags_q. A branch in the same cycle as a flag write therefore sees the new flags.
- Conditions, with Z/S/V the effective flags:
  - 0 ALWAYS
  - 1 EQ = Z
  - 2 NE = !Z
  - 3 LT = S^V
  - 4 GE = !(S^V)
  - 5 OV = V
  - 6 NEG = S
  - 7 NEVER
- States: IDLE, REDIRECT.
  - br_ready = (state==IDLE), combinational from state only.
  - redirect_valid = (state==REDIRECT), registered.
- IDLE:
  - Branch accepted when br_valid && br_ready.
  - Taken: redirect_addr <= br_target, taken_cnt increments, go to REDIRECT. redirect_valid is high from the next cycle (1-cycle latency).
  - Not taken or no branch: stay in IDLE; redirect_addr holds its value.
- REDIRECT:
  - redirect_addr and redirect_valid are held stable until redirect_ready=1.
  - On redirect_ready, return to IDLE at that edge. br_ready rises the cycle after the handshake; there is no same-cycle re-accept.
  - br_valid is ignored while br_ready=0; the requester must hold the request.
- taken_cnt: +1 per accepted taken branch; saturates at all-ones with no wrap.
- Reset mid-REDIRECT: redirect_valid drops asynchronously; the pending redirect is discarded and not retried.
- br_cond is 3 bits, so no illegal encodings exist.

Test Plan:
- Reset during REDIRECT with redirect_addr=0x1234 -> redirect_valid, flags_q, taken_cnt go to 0 immediately, without waiting for a clock edge.
- flag_we=1 with zero=1 and, in the same cycle, br_valid=1, cond=EQ, target=0x00A0, while flags_q.zero=0 -> taken via bypass; next cycle redirect_valid=1, redirect_addr=0x00A0, flags_q=3'b001, taken_cnt=1.
- flags_q={V=1,S=0,Z=0}, branches LT then GE, target 0x0200, redirect_ready=1 -> LT taken (redirect 0x0200); GE not taken; taken_cnt=1.
- Taken branch with redirect_ready=0 for 4 cycles and a new br_valid (target 0x0300) held throughout -> redirect_valid and redirect_addr stable at the first target; br_ready=0 throughout. After redirect_ready=1: IDLE next cycle, second branch accepted.
- flag_we pulse with overflow=1 while in REDIRECT -> flags_q updates to 3'b100; redirect unaffected.
- CNT_W=4, 17 taken ALWAYS branches, each redirect acknowledged -> taken_cnt reaches 4'hF and stays there; NEVER branches leave redirect_valid=0 and the count unchanged.
